// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction fetch stage:
// next-PC select encodings and the default reset vector.
package if_stage_pkg;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_next_pc.sv
// Redirect decision and control-transfer target computation
// for the instruction in the IF/ID register.
module if_next_pc
    import if_stage_pkg::*;
(
    input  logic        id_valid,
    input  logic        stall_id,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jimm,
    input  logic [31:0] jr_target,
    input  logic [31:0] id_pc_plus4,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    logic [31:0] w_br_off;
    logic        w_xfer;

    assign w_br_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        w_xfer   = 1'b0;
        o_target = id_pc_plus4;
        unique case (pc_src)
            PCSRC_SEQ: begin
                w_xfer   = 1'b0;
                o_target = id_pc_plus4;
            end
            PCSRC_BRANCH: begin
                w_xfer   = branch_taken;
                o_target = id_pc_plus4 + w_br_off;
            end
            PCSRC_JUMP: begin
                w_xfer   = 1'b1;
                o_target = {id_pc_plus4[31:28], jimm, 2'b00};
            end
            PCSRC_JR: begin
                w_xfer   = 1'b1;
                o_target = {jr_target[31:2], 2'b00};
            end
            default: begin
                w_xfer   = 1'b0;
                o_target = id_pc_plus4;
            end
        endcase
    end

    // A bubble or a stalled decode must never steer the PC.
    assign o_redirect = id_valid & ~stall_id & w_xfer;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch request to
// instruction memory and the IF/ID pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall_id,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jimm,
    input  logic [31:0] jr_target,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    if_next_pc u_next_pc (
        .id_valid     (r_id_valid),
        .stall_id     (stall_id),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .jimm         (jimm),
        .jr_target    (jr_target),
        .id_pc_plus4  (r_id_pc4),
        .o_redirect   (w_redirect),
        .o_target     (w_target)
    );

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_id_inst  <= '0;
            r_id_pc    <= '0;
            r_id_pc4   <= '0;
            r_id_valid <= 1'b0;
        end else if (w_redirect) begin
            // Wrong-path fetch data is dropped; no delay slot.
            r_pc       <= w_target;
            r_id_valid <= 1'b0;
        end else if (stall_id) begin
            r_pc       <= r_pc;
            r_id_valid <= r_id_valid;
        end else if (imem_ready) begin
            r_pc       <= w_pc_plus4;
            r_id_inst  <= imem_rdata;
            r_id_pc    <= r_pc;
            r_id_pc4   <= w_pc_plus4;
            r_id_valid <= 1'b1;
        end else begin
            r_id_valid <= 1'b0;
        end
    end

    assign imem_addr   = r_pc;
    assign imem_req    = ~reset;
    assign id_inst     = r_id_inst;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc4;
    assign id_valid    = r_id_valid;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus randomized
// traffic checked against a behavioural fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall_id;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] jimm;
    logic [31:0] jr_target;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_inst, m_ipc, m_ipc4;
    logic        m_valid;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .stall_id     (stall_id),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .jimm         (jimm),
        .jr_target    (jr_target),
        .id_inst      (id_inst),
        .id_pc        (id_pc),
        .id_pc_plus4  (id_pc_plus4),
        .id_valid     (id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    // One clock: advance the model from the rules, then the DUT.
    task automatic tick();
        logic [31:0] tgt;
        logic        jump;
        logic [31:0] n_pc, n_inst, n_ipc, n_ipc4;
        logic        n_valid;
        n_pc = m_pc; n_inst = m_inst; n_ipc = m_ipc;
        n_ipc4 = m_ipc4; n_valid = m_valid;
        jump = (pc_src == 2'd2) || (pc_src == 2'd3) ||
               (pc_src == 2'd1 && branch_taken);
        if (pc_src == 2'd1)
            tgt = m_ipc4 + 32'($signed(imm16)) * 32'd4;
        else if (pc_src == 2'd2)
            tgt = (m_ipc4 & 32'hF000_0000) + {6'd0, jimm} * 32'd4;
        else
            tgt = jr_target & ~32'd3;
        if (reset) begin
            n_pc = 0; n_inst = 0; n_ipc = 0; n_ipc4 = 0; n_valid = 0;
        end else if (m_valid && !stall_id && jump) begin
            n_pc = tgt; n_valid = 0;
        end else if (stall_id) begin
        end else if (imem_ready) begin
            n_inst = mem(m_pc); n_ipc = m_pc;
            n_ipc4 = m_pc + 32'd4; n_pc = m_pc + 32'd4; n_valid = 1;
        end else begin
            n_valid = 0;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_inst = n_inst; m_ipc = n_ipc;
        m_ipc4 = n_ipc4; m_valid = n_valid;
    endtask

    task automatic idle_inputs();
        stall_id = 0; pc_src = 0; branch_taken = 0;
        imm16 = 0; jimm = 0; jr_target = 0; imem_ready = 1;
    endtask

    // Leaves id_pc == a, id_valid == 1, PC == a+4.
    task automatic goto(input logic [31:0] a);
        idle_inputs();
        tick();
        pc_src = 2'd3; jr_target = a;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        tick(); tick();
        checks++;
        if (imem_addr !== 32'h0 || id_valid !== 1'b0 || id_inst !== 32'h0 ||
            id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin
            failures++;
            $display("FAIL reset_state addr=%h v=%b inst=%h pc=%h pc4=%h expected all 0",
                     imem_addr, id_valid, id_inst, id_pc, id_pc_plus4);
        end
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got=%b expected=0", imem_req);
        end
        reset = 0;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL req_after_reset got=%b expected=1", imem_req);
        end
    endtask

    task automatic test_sequential();
        idle_inputs();
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (imem_addr !== 32'(4 * k) || id_pc !== 32'(4 * (k - 1)) ||
                id_pc_plus4 !== 32'(4 * k) || id_valid !== 1'b1 ||
                id_inst !== mem(32'(4 * (k - 1)))) begin
                failures++;
                $display("FAIL seq_%0d addr=%h idpc=%h pc4=%h v=%b inst=%h expected addr=%h idpc=%h",
                         k, imem_addr, id_pc, id_pc_plus4, id_valid, id_inst,
                         32'(4 * k), 32'(4 * (k - 1)));
            end
        end
    endtask

    task automatic test_branch();
        goto(32'h100);
        pc_src = 2'd1; branch_taken = 1; imm16 = 16'hFFFE;
        tick();
        checks++;
        if (imem_addr !== 32'h0FC || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL branch_taken addr=%h v=%b expected addr=000000fc v=0",
                     imem_addr, id_valid);
        end
        idle_inputs();
        tick();
        checks++;
        if (id_pc !== 32'h0FC || id_valid !== 1'b1) begin
            failures++;
            $display("FAIL branch_land idpc=%h v=%b expected idpc=000000fc v=1",
                     id_pc, id_valid);
        end
        goto(32'h100);
        pc_src = 2'd1; branch_taken = 0; imm16 = 16'hFFFE;
        tick();
        checks++;
        if (imem_addr !== 32'h108 || id_pc !== 32'h104 || id_valid !== 1'b1) begin
            failures++;
            $display("FAIL branch_not_taken addr=%h idpc=%h v=%b expected 108/104/1",
                     imem_addr, id_pc, id_valid);
        end
    endtask

    task automatic test_jump();
        goto(32'h3000_0010);
        pc_src = 2'd2; jimm = 26'h0000040;
        tick();
        checks++;
        if (imem_addr !== 32'h3000_0100 || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL jump addr=%h v=%b expected addr=30000100 v=0",
                     imem_addr, id_valid);
        end
        idle_inputs();
        tick();
        pc_src = 2'd3; jr_target = 32'h0000_2003;
        tick();
        checks++;
        if (imem_addr !== 32'h0000_2000) begin
            failures++;
            $display("FAIL jr addr=%h expected=00002000", imem_addr);
        end
    endtask

    task automatic test_stall();
        goto(32'h200);
        pc_src = 2'd2; jimm = 26'h0000123; stall_id = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (imem_addr !== 32'h204 || id_pc !== 32'h200 ||
                id_valid !== 1'b1 || id_inst !== mem(32'h200)) begin
                failures++;
                $display("FAIL stall_%0d addr=%h idpc=%h v=%b expected 204/200/1",
                         k, imem_addr, id_pc, id_valid);
            end
        end
        stall_id = 0;
        tick();
        checks++;
        if (imem_addr !== 32'h0000_048C || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release addr=%h v=%b expected addr=0000048c v=0",
                     imem_addr, id_valid);
        end
    endtask

    task automatic test_wait();
        goto(32'h3C);
        imem_ready = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (imem_addr !== 32'h40 || id_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_%0d addr=%h v=%b expected addr=00000040 v=0",
                         k, imem_addr, id_valid);
            end
        end
        imem_ready = 1;
        tick();
        checks++;
        if (id_pc !== 32'h40 || id_valid !== 1'b1 || imem_addr !== 32'h44) begin
            failures++;
            $display("FAIL wait_done idpc=%h v=%b addr=%h expected 40/1/44",
                     id_pc, id_valid, imem_addr);
        end
        pc_src = 2'd2; jimm = 26'h0000200;
        tick();
        checks++;
        if (imem_addr !== 32'h800 || id_valid !== 1'b0 ||
            id_inst !== mem(32'h40)) begin
            failures++;
            $display("FAIL redirect_drop addr=%h v=%b inst=%h expected 800/0/%h",
                     imem_addr, id_valid, id_inst, mem(32'h40));
        end
    endtask

    task automatic test_wrap_and_reset();
        goto(32'hFFFF_FFF8);
        tick();
        checks++;
        if (imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC ||
            id_pc_plus4 !== 32'h0 || id_valid !== 1'b1) begin
            failures++;
            $display("FAIL pc_wrap addr=%h idpc=%h pc4=%h v=%b expected 0/fffffffc/0/1",
                     imem_addr, id_pc, id_pc_plus4, id_valid);
        end
        goto(32'h500);
        imem_ready = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        #1;
        checks++;
        if (imem_addr !== 32'h0 || id_valid !== 1'b0 || id_inst !== 32'h0 ||
            imem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_wait addr=%h v=%b inst=%h req=%b expected 0/0/0/1",
                     imem_addr, id_valid, id_inst, imem_req);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset        = ($urandom_range(0, 49) == 0);
            stall_id     = ($urandom_range(0, 4) == 0);
            imem_ready   = ($urandom_range(0, 3) != 0);
            pc_src       = 2'($urandom_range(0, 3));
            branch_taken = 1'($urandom);
            imm16        = 16'($urandom);
            jimm         = 26'($urandom);
            jr_target    = $urandom;
            tick();
            checks++;
            if (imem_addr !== m_pc || id_inst !== m_inst || id_pc !== m_ipc ||
                id_pc_plus4 !== m_ipc4 || id_valid !== m_valid) begin
                failures++;
                $display("FAIL random_%0d addr=%h/%h inst=%h/%h idpc=%h/%h pc4=%h/%h v=%b/%b (got/expected)",
                         k, imem_addr, m_pc, id_inst, m_inst, id_pc, m_ipc,
                         id_pc_plus4, m_ipc4, id_valid, m_valid);
            end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        m_pc = 0; m_inst = 0; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_wait();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
